gp_rr_arbiter_n: RTL and testbench

- N-input output-channel arbiter for the bufferless router; successor of the 2-input golden-packet arbiter.
- Golden-packet (GP) flits win first, ordered by lowest packet ID.
- Non-golden contention is resolved round-robin, fixing the fixed-index bias of the 2-input version.
- Per-input starvation counters promote long-waiting inputs. The grant is registered: one decision per cycle when the channel is ready.

---
 rtl/gp_rr_arbiter_n_pkg.sv | 13 +
 rtl/gp_rr_arbiter_n_rr_pick_n.sv | 29 ++
 rtl/gp_rr_arbiter_n.sv | 137 +++++++++++++
 tb/tb_gp_rr_arbiter_n.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gp_rr_arbiter_n_pkg.sv
// Shared definitions for the N-input golden-packet arbiter:
// grant class encodings and the default packet-ID width.
package gp_rr_arbiter_n_pkg;

    localparam int FLITNUM_SIZE = 8;

    typedef enum logic [1:0] {
        CLS_NORMAL  = 2'd0,
        CLS_STARVED = 2'd1,
        CLS_GOLDEN  = 2'd2
    } grant_class_e;

endpackage

// File: rtl/gp_rr_arbiter_n_rr_pick_n.sv
// Combinational round-robin picker: first set bit of mask_i at or after
// ptr_i, scanning upward with wrap-around.
module rr_pick_n #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int j;

    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            j = (int'(ptr_i) + off) % N;
            if (mask_i[j]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/gp_rr_arbiter_n.sv
// N-input output-channel arbiter: golden packets first (lowest ID), then
// starved inputs, then normal inputs, both round-robin; grant registered.
module gp_rr_arbiter_n
    import gp_rr_arbiter_n_pkg::*;
#(
    parameter int N_IN         = 4,
    parameter int ID_W         = FLITNUM_SIZE,
    parameter int STARVE_LIMIT = 8,
    localparam int IDX_W       = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IN-1:0]      valid,
    input  logic [N_IN-1:0]      gp,
    input  logic [N_IN*ID_W-1:0] pkt_id,
    input  logic                 out_ready,
    output logic [N_IN-1:0]      grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid,
    output logic [1:0]           grant_class
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [N_IN-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             grant_valid_q, grant_valid_d;
    grant_class_e     grant_class_q, grant_class_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] wait_cnt_q [N_IN];
    logic [CNT_W-1:0] wait_cnt_d [N_IN];

    logic [N_IN-1:0]  gold_mask, starve_mask, norm_mask;
    logic             gold_found, starve_found, norm_found;
    logic [IDX_W-1:0] gold_idx, starve_idx, norm_idx, win_idx;
    logic [ID_W-1:0]  gold_id;
    logic             decide;

    assign decide = out_ready && (|valid);

    always_comb begin
        gold_mask   = valid & gp;
        starve_mask = '0;
        for (int i = 0; i < N_IN; i++) begin
            starve_mask[i] = valid[i] && !gp[i] && (wait_cnt_q[i] == LIMIT);
        end
        norm_mask = valid & ~gp & ~starve_mask;
    end

    // Strict less-than while scanning upward keeps the lowest index on ID ties.
    always_comb begin
        gold_found = 1'b0;
        gold_idx   = '0;
        gold_id    = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (gold_mask[i] && (!gold_found || pkt_id[i*ID_W +: ID_W] < gold_id)) begin
                gold_found = 1'b1;
                gold_idx   = IDX_W'(i);
                gold_id    = pkt_id[i*ID_W +: ID_W];
            end
        end
    end

    rr_pick_n #(.N(N_IN), .IDX_W(IDX_W)) u_pick_starved (
        .mask_i  (starve_mask),
        .ptr_i   (rr_ptr_q),
        .found_o (starve_found),
        .idx_o   (starve_idx)
    );

    rr_pick_n #(.N(N_IN), .IDX_W(IDX_W)) u_pick_normal (
        .mask_i  (norm_mask),
        .ptr_i   (rr_ptr_q),
        .found_o (norm_found),
        .idx_o   (norm_idx)
    );

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        grant_d       = '0;
        grant_idx_d   = '0;
        grant_valid_d = 1'b0;
        grant_class_d = CLS_NORMAL;
        rr_ptr_d      = rr_ptr_q;
        win_idx       = '0;
        if (decide) begin
            if (gold_found) begin
                win_idx       = gold_idx;
                grant_class_d = CLS_GOLDEN;
            end else begin
                win_idx       = starve_found ? starve_idx : norm_idx;
                grant_class_d = starve_found ? CLS_STARVED : CLS_NORMAL;
                rr_ptr_d      = (int'(win_idx) == N_IN - 1) ? '0 : win_idx + 1'b1;
            end
            grant_d       = N_IN'(1) << win_idx;
            grant_idx_d   = win_idx;
            grant_valid_d = 1'b1;
        end
        for (int i = 0; i < N_IN; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (decide) begin
                if (!valid[i] || grant_d[i]) begin
                    wait_cnt_d[i] = '0;
                end else if (!gp[i] && wait_cnt_q[i] != LIMIT) begin
                    wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            grant_class_q <= CLS_NORMAL;
            rr_ptr_q      <= '0;
            for (int i = 0; i < N_IN; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            grant_class_q <= grant_class_d;
            rr_ptr_q      <= rr_ptr_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign grant_class = grant_class_q;

endmodule

// File: tb/tb_gp_rr_arbiter_n.sv
// Directed bench for gp_rr_arbiter_n: one default instance (STARVE_LIMIT=8)
// and one with STARVE_LIMIT=2 for the promotion scenario.
module tb_gp_rr_arbiter_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  valid;
    logic [3:0]  gp;
    logic [31:0] pkt_id;
    logic        out_ready;

    logic [3:0]  grant_a, grant_b;
    logic [1:0]  idx_a, idx_b;
    logic        gv_a, gv_b;
    logic [1:0]  cls_a, cls_b;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    gp_rr_arbiter_n #(.N_IN(4), .ID_W(8), .STARVE_LIMIT(8)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .gp          (gp),
        .pkt_id      (pkt_id),
        .out_ready   (out_ready),
        .grant       (grant_a),
        .grant_idx   (idx_a),
        .grant_valid (gv_a),
        .grant_class (cls_a)
    );

    gp_rr_arbiter_n #(.N_IN(4), .ID_W(8), .STARVE_LIMIT(2)) u_starve (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .gp          (gp),
        .pkt_id      (pkt_id),
        .out_ready   (out_ready),
        .grant       (grant_b),
        .grant_idx   (idx_b),
        .grant_valid (gv_b),
        .grant_class (cls_b)
    );

    // Packed view: {grant, grant_idx, grant_valid, grant_class}
    function automatic logic [8:0] obs_a();
        return {grant_a, idx_a, gv_a, cls_a};
    endfunction

    function automatic logic [8:0] obs_b();
        return {grant_b, idx_b, gv_b, cls_b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = '0; gp = '0; pkt_id = '0; out_ready = 1'b0;
        tick();
        checks++;
        if (obs_a() !== 9'b0) $display("FAIL reset_a got=%b exp=%b", obs_a(), 9'b0);
        else passed++;
        checks++;
        if (obs_b() !== 9'b0) $display("FAIL reset_b got=%b exp=%b", obs_b(), 9'b0);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_rotation();
        logic [1:0] exp_idx [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [8:0] exp;
        valid = 4'b1111; gp = 4'b0000; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp = {4'b0001 << exp_idx[c], exp_idx[c], 1'b1, 2'd0};
            checks++;
            if (obs_a() !== exp) $display("FAIL rotation[%0d] got=%b exp=%b", c, obs_a(), exp);
            else passed++;
        end
    endtask

    // Pointer is at 0 here; golden grants must leave it there.
    task automatic test_golden();
        valid = 4'b1111; gp = 4'b0110; out_ready = 1'b1;
        pkt_id = {8'd9, 8'd3, 8'd5, 8'd0};
        tick();
        checks++;
        if (obs_a() !== {4'b0100, 2'd2, 1'b1, 2'd2})
            $display("FAIL golden_min got=%b exp=%b", obs_a(), {4'b0100, 2'd2, 1'b1, 2'd2});
        else passed++;
        pkt_id = {8'd9, 8'd5, 8'd5, 8'd0};
        tick();
        checks++;
        if (obs_a() !== {4'b0010, 2'd1, 1'b1, 2'd2})
            $display("FAIL golden_tie got=%b exp=%b", obs_a(), {4'b0010, 2'd1, 1'b1, 2'd2});
        else passed++;
        gp = 4'b0000;
        tick();
        checks++;
        if (obs_a() !== {4'b0001, 2'd0, 1'b1, 2'd0})
            $display("FAIL golden_ptr_hold got=%b exp=%b", obs_a(), {4'b0001, 2'd0, 1'b1, 2'd0});
        else passed++;
    endtask

    // Pointer is at 1 here.
    task automatic test_ready_stall();
        valid = 4'b1111; gp = 4'b0000; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs_a() !== 9'b0) $display("FAIL stall[%0d] got=%b exp=%b", c, obs_a(), 9'b0);
            else passed++;
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (obs_a() !== {4'b0010, 2'd1, 1'b1, 2'd0})
            $display("FAIL stall_resume got=%b exp=%b", obs_a(), {4'b0010, 2'd1, 1'b1, 2'd0});
        else passed++;
    endtask

    // Pointer is at 2 here.
    task automatic test_mid_reset();
        valid = 4'b1111; gp = 4'b0000; out_ready = 1'b1;
        tick();
        checks++;
        if (obs_a() !== {4'b0100, 2'd2, 1'b1, 2'd0})
            $display("FAIL pre_reset got=%b exp=%b", obs_a(), {4'b0100, 2'd2, 1'b1, 2'd0});
        else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if (obs_a() !== 9'b0) $display("FAIL mid_reset got=%b exp=%b", obs_a(), 9'b0);
        else passed++;
        reset = 1'b0;
        tick();
        checks++;
        if (obs_a() !== {4'b0001, 2'd0, 1'b1, 2'd0})
            $display("FAIL post_reset got=%b exp=%b", obs_a(), {4'b0001, 2'd0, 1'b1, 2'd0});
        else passed++;
    endtask

    // Pointer is at 1 here; a lone requester at 2 moves it to 3.
    task automatic test_single();
        valid = 4'b0100; gp = 4'b0000; out_ready = 1'b1;
        tick();
        checks++;
        if (obs_a() !== {4'b0100, 2'd2, 1'b1, 2'd0})
            $display("FAIL single got=%b exp=%b", obs_a(), {4'b0100, 2'd2, 1'b1, 2'd0});
        else passed++;
        valid = 4'b1111;
        tick();
        checks++;
        if (obs_a() !== {4'b1000, 2'd3, 1'b1, 2'd0})
            $display("FAIL single_ptr got=%b exp=%b", obs_a(), {4'b1000, 2'd3, 1'b1, 2'd0});
        else passed++;
    endtask

    task automatic test_no_valid();
        valid = 4'b0000; gp = 4'b1111; out_ready = 1'b1;
        tick();
        checks++;
        if (obs_a() !== 9'b0) $display("FAIL no_valid got=%b exp=%b", obs_a(), 9'b0);
        else passed++;
    endtask

    task automatic test_starvation();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        valid = 4'b0011; gp = 4'b0001; out_ready = 1'b1; pkt_id = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (obs_b() !== {4'b0001, 2'd0, 1'b1, 2'd2})
                $display("FAIL starve_golden[%0d] got=%b exp=%b", c, obs_b(), {4'b0001, 2'd0, 1'b1, 2'd2});
            else passed++;
        end
        gp = 4'b0000;
        tick();
        checks++;
        if (obs_b() !== {4'b0010, 2'd1, 1'b1, 2'd1})
            $display("FAIL starve_promote got=%b exp=%b", obs_b(), {4'b0010, 2'd1, 1'b1, 2'd1});
        else passed++;
        tick();
        checks++;
        if (obs_b() !== {4'b0001, 2'd0, 1'b1, 2'd0})
            $display("FAIL starve_after got=%b exp=%b", obs_b(), {4'b0001, 2'd0, 1'b1, 2'd0});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_golden();
        test_ready_stall();
        test_mid_reset();
        test_single();
        test_no_valid();
        test_starvation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
